// File: rtl/load_store_unit_if.sv
// Pipeline-request and data-memory signals of the load/store unit.
// The unit itself connects through the slave modport; the environment uses master.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_byte;
    logic        req_unsigned;
    logic [8:0]  req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [8:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    modport slave (
        input  req_valid, req_write, req_byte, req_unsigned, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_byte, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: 16-bit word and (with LSU_BYTE_ACCESS_EN defined) byte accesses to a
// word-wide data memory; byte stores are done as read-merge-write.
module load_store_unit (
    input logic              clk,
    input logic              rst_n,
    load_store_unit_if.slave bus
);
`ifdef LSU_BYTE_ACCESS_EN
    typedef enum logic [1:0] {IDLE, ACCESS, MERGE_WR, ERR} state_t;
`else
    typedef enum logic [1:0] {IDLE, ACCESS, ERR} state_t;
`endif

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [8:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic [15:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic        mem_read_c, mem_write_c;
    logic [8:0]  mem_addr_c;
    logic [15:0] mem_wdata_c;
    logic        accept;
    logic        illegal;

    assign accept = bus.req_valid && (state_q == IDLE);

`ifdef LSU_BYTE_ACCESS_EN
    logic        byte_q, byte_d;
    logic        unsigned_q, unsigned_d;
    logic [7:0]  rd_byte;
    logic [15:0] load_byte_ext;
    logic [15:0] merged_word;

    assign illegal       = !bus.req_byte && bus.req_addr[0];
    assign rd_byte       = addr_q[0] ? bus.mem_rdata[15:8] : bus.mem_rdata[7:0];
    assign load_byte_ext = unsigned_q ? {8'h00, rd_byte} : {{8{rd_byte[7]}}, rd_byte};
    assign merged_word   = addr_q[0] ? {wdata_q[7:0], bus.mem_rdata[7:0]}
                                     : {bus.mem_rdata[15:8], wdata_q[7:0]};
`else
    assign illegal = bus.req_byte || bus.req_addr[0];
`endif

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d      = state_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        mem_addr_c   = '0;
        mem_wdata_c  = '0;
`ifdef LSU_BYTE_ACCESS_EN
        byte_d       = byte_q;
        unsigned_d   = unsigned_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    write_d = bus.req_write;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
`ifdef LSU_BYTE_ACCESS_EN
                    byte_d     = bus.req_byte;
                    unsigned_d = bus.req_unsigned;
`endif
                    state_d = illegal ? ERR : ACCESS;
                end
            end
            ACCESS: begin
                mem_addr_c = addr_q;
                state_d    = IDLE;
`ifdef LSU_BYTE_ACCESS_EN
                if (byte_q) begin
                    mem_read_c = 1'b1;
                    if (write_q) begin
                        // wdata_q is reused to hold the merged word for the write-back cycle
                        wdata_d = merged_word;
                        state_d = MERGE_WR;
                    end else begin
                        resp_rdata_d = load_byte_ext;
                        resp_valid_d = 1'b1;
                    end
                end else
`endif
                begin
                    resp_valid_d = 1'b1;
                    if (write_q) begin
                        mem_write_c = 1'b1;
                        mem_wdata_c = wdata_q;
                    end else begin
                        mem_read_c   = 1'b1;
                        resp_rdata_d = bus.mem_rdata;
                    end
                end
            end
`ifdef LSU_BYTE_ACCESS_EN
            MERGE_WR: begin
                mem_write_c  = 1'b1;
                mem_addr_c   = addr_q;
                mem_wdata_c  = wdata_q;
                resp_valid_d = 1'b1;
                state_d      = IDLE;
            end
`endif
            ERR: begin
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
`ifdef LSU_BYTE_ACCESS_EN
            byte_q       <= 1'b0;
            unsigned_q   <= 1'b0;
`endif
        end else begin
            // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
            state_q      <= state_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
`ifdef LSU_BYTE_ACCESS_EN
            byte_q       <= byte_d;
            unsigned_q   <= unsigned_d;
`endif
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.mem_read   = mem_read_c;
    assign bus.mem_write  = mem_write_c;
    assign bus.mem_addr   = mem_addr_c;
    assign bus.mem_wdata  = mem_wdata_c;
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, reset-abort sequence and
// random traffic compared against a byte-array reference model.
module tb_load_store_unit;
`ifdef LSU_BYTE_ACCESS_EN
    localparam bit BE = 1'b1;
`else
    localparam bit BE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    load_store_unit_if bus ();
    load_store_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Data memory seen by the DUT: combinational read, write on the rising edge.
    logic [15:0] dmem [256] = '{default: 16'h0000};
    assign bus.mem_rdata = dmem[bus.mem_addr[8:1]];
    always @(posedge clk) if (bus.mem_write) dmem[bus.mem_addr[8:1]] <= bus.mem_wdata;

    // Reference model: byte-addressed storage, little-endian lanes.
    logic [7:0] rb [512] = '{default: 8'h00};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_exec(input logic wr, input logic by, input logic un,
                              input logic [8:0] a, input logic [15:0] wd,
                              output logic [15:0] rd, output logic err,
                              output int lat, output int nrd, output int nwr);
        logic [7:0] b;
        rd = 16'h0; err = 1'b0; lat = 2; nrd = 0; nwr = 0;
        if ((!by && a[0]) || (by && !BE)) begin
            err = 1'b1;
        end else if (!by && !wr) begin
            rd = {rb[a + 9'd1], rb[a]}; nrd = 1;
        end else if (!by && wr) begin
            rb[a] = wd[7:0]; rb[a + 9'd1] = wd[15:8]; nwr = 1;
        end else if (!wr) begin
            b = rb[a]; rd = un ? {8'h00, b} : {{8{b[7]}}, b}; nrd = 1;
        end else begin
            rb[a] = wd[7:0]; lat = 3; nrd = 1; nwr = 1;
        end
    endtask

    // Must be called at a falling edge; returns at the falling edge where resp_valid is seen.
    task automatic do_req(input logic wr, input logic by, input logic un,
                          input logic [8:0] a, input logic [15:0] wd,
                          output logic [15:0] rd, output logic err, output int lat,
                          output int nrd, output int nwr, output logic [8:0] saddr,
                          output logic [15:0] swdata, output logic rdy_issue,
                          output logic rdy_resp, output int both);
        rd = 16'h0; err = 1'b0; lat = 99; nrd = 0; nwr = 0; saddr = '0; swdata = '0;
        rdy_resp = 1'b0; both = 0;
        bus.req_valid = 1'b1; bus.req_write = wr; bus.req_byte = by;
        bus.req_unsigned = un; bus.req_addr = a; bus.req_wdata = wd;
        rdy_issue = bus.req_ready;
        @(posedge clk);
        #1;
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'($urandom_range(0, 1));
        bus.req_byte     = 1'($urandom_range(0, 1));
        bus.req_unsigned = 1'($urandom_range(0, 1));
        bus.req_addr     = 9'($urandom);
        bus.req_wdata    = 16'($urandom);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (bus.mem_read) nrd++;
            if (bus.mem_write) begin nwr++; swdata = bus.mem_wdata; end
            if (bus.mem_read && bus.mem_write) both++;
            if (bus.mem_read || bus.mem_write) saddr = bus.mem_addr;
            if (bus.resp_valid) begin
                lat = k; rd = bus.resp_rdata; err = bus.resp_err; rdy_resp = bus.req_ready;
                break;
            end
        end
    endtask

    typedef struct {
        logic        wr, by, un;
        logic [8:0]  addr;
        logic [15:0] wd;
        logic [15:0] exp_rd;
        logic        exp_err;
        int          exp_lat, exp_nrd, exp_nwr;
    } vec_t;

    vec_t vecs [12];

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rd, m_rd, swd;
        logic        err, m_err, rdy_i, rdy_r;
        logic [8:0]  saddr;
        int          lat, nrd, nwr, both, m_lat, m_nrd, m_nwr, seen;
        logic        wr, by, un;
        logic [8:0]  a;
        logic [15:0] wd;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 9'h010, 16'hBEEF, 16'h0000, 1'b0, 2, 0, 1};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 9'h010, 16'h0000, 16'hBEEF, 1'b0, 2, 1, 0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 9'h011, 16'h0000, 16'h0000, 1'b1, 2, 0, 0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 9'h020, 16'h1234, 16'h0000, 1'b0, 2, 0, 1};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 9'h021, 16'h55AB, 16'h0000, !BE, BE ? 3 : 2, BE ? 1 : 0, BE ? 1 : 0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 9'h020, 16'h0000, BE ? 16'hAB34 : 16'h1234, 1'b0, 2, 1, 0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 9'h030, 16'h80FF, 16'h0000, 1'b0, 2, 0, 1};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 9'h031, 16'h0000, BE ? 16'hFF80 : 16'h0000, !BE, 2, BE ? 1 : 0, 0};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 9'h030, 16'h0000, BE ? 16'h00FF : 16'h0000, !BE, 2, BE ? 1 : 0, 0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 9'h002, 16'h0000, 16'h0000, !BE, 2, BE ? 1 : 0, 0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 9'h013, 16'hFFFF, 16'h0000, 1'b1, 2, 0, 0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 9'h012, 16'h0000, 16'h0000, 1'b0, 2, 1, 0};

        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_byte = 1'b0;
        bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_resp_rdata", bus.resp_rdata, 0);
        check("rst_resp_err", bus.resp_err, 0);
        check("rst_mem_read", bus.mem_read, 0);
        check("rst_mem_write", bus.mem_write, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_req_ready", bus.req_ready, 1);

        // Directed vectors, issued back-to-back
        for (int i = 0; i < 12; i++) begin
            do_req(vecs[i].wr, vecs[i].by, vecs[i].un, vecs[i].addr, vecs[i].wd,
                   rd, err, lat, nrd, nwr, saddr, swd, rdy_i, rdy_r, both);
            model_exec(vecs[i].wr, vecs[i].by, vecs[i].un, vecs[i].addr, vecs[i].wd,
                       m_rd, m_err, m_lat, m_nrd, m_nwr);
            check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
            check($sformatf("v%0d_err", i), err, vecs[i].exp_err);
            check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d_reads", i), nrd, vecs[i].exp_nrd);
            check($sformatf("v%0d_writes", i), nwr, vecs[i].exp_nwr);
            check($sformatf("v%0d_ready_issue", i), rdy_i, 1);
            check($sformatf("v%0d_ready_at_resp", i), rdy_r, 1);
            check($sformatf("v%0d_rd_wr_excl", i), both, 0);
            if (vecs[i].exp_nrd + vecs[i].exp_nwr > 0)
                check($sformatf("v%0d_mem_addr", i), saddr, vecs[i].addr);
            if (vecs[i].exp_nwr > 0 && !vecs[i].by)
                check($sformatf("v%0d_mem_wdata", i), swd, vecs[i].wd);
        end

        // Reset during the write phase of a store: no write, no response
        do_req(1'b1, 1'b0, 1'b0, 9'h040, 16'h5A5A, rd, err, lat, nrd, nwr, saddr, swd, rdy_i, rdy_r, both);
        model_exec(1'b1, 1'b0, 1'b0, 9'h040, 16'h5A5A, m_rd, m_err, m_lat, m_nrd, m_nwr);
        check("pre_store_latency", lat, 2);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_byte = BE;
        bus.req_addr = 9'h040; bus.req_wdata = BE ? 16'h0011 : 16'hDEAD;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        if (BE) begin
            @(posedge clk);
            #1;
        end
        check("abort_pre_mem_write", bus.mem_write, 1);
        rst_n = 1'b0;
        #1;
        check("abort_mem_write_async", bus.mem_write, 0);
        check("abort_mem_read_async", bus.mem_read, 0);
        check("abort_ready_in_reset", bus.req_ready, 1);
        seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.resp_valid || bus.mem_write) seen++;
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (bus.resp_valid || bus.mem_write) seen++;
        end
        check("abort_no_resp_or_write", seen, 0);
        check("abort_ready_after_reset", bus.req_ready, 1);
        do_req(1'b0, 1'b0, 1'b0, 9'h040, 16'h0000, rd, err, lat, nrd, nwr, saddr, swd, rdy_i, rdy_r, both);
        model_exec(1'b0, 1'b0, 1'b0, 9'h040, 16'h0000, m_rd, m_err, m_lat, m_nrd, m_nwr);
        check("abort_mem_unchanged", rd, 16'h5A5A);
        check("abort_model_agrees", rd, m_rd);

        // Random traffic against the reference model
        for (int i = 0; i < 200; i++) begin
            wr = 1'($urandom_range(0, 1));
            by = 1'($urandom_range(0, 1));
            un = 1'($urandom_range(0, 1));
            a  = 9'($urandom_range(0, 63));
            wd = 16'($urandom);
            do_req(wr, by, un, a, wd, rd, err, lat, nrd, nwr, saddr, swd, rdy_i, rdy_r, both);
            model_exec(wr, by, un, a, wd, m_rd, m_err, m_lat, m_nrd, m_nwr);
            check($sformatf("rnd%0d_rdata", i), rd, m_rd);
            check($sformatf("rnd%0d_err", i), err, m_err);
            check($sformatf("rnd%0d_latency", i), lat, m_lat);
            check($sformatf("rnd%0d_reads", i), nrd, m_nrd);
            check($sformatf("rnd%0d_writes", i), nwr, m_nwr);
            check($sformatf("rnd%0d_rd_wr_excl", i), both, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have no parameters; all widths are fixed: 9-bit byte address, 16-bit data.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port req_valid, input, 1: a pipeline request is present.
REQ-005 SHALL have port req_ready, output, 1: the unit can accept a request.
REQ-006 SHALL have port req_write, input, 1: 1 means store, 0 means load.
REQ-007 SHALL have port req_byte, input, 1: 1 means byte access, 0 means 16-bit word access.
REQ-008 SHALL have port req_unsigned, input, 1: byte loads zero-extend when 1 and sign-extend when 0.
REQ-009 SHALL have port req_addr, input, 9: byte address.
REQ-010 SHALL have port req_wdata, input, 16: store data; for byte stores only bits [7:0] are used.
REQ-011 SHALL have port resp_valid, output, 1: a one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata, output, 16: load result, 0 for stores and errors.
REQ-013 SHALL have port resp_err, output, 1: the request was illegal; it is qualified by resp_valid.
REQ-014 SHALL have ports mem_read and mem_write, output, 1 each: data-memory strobes.
REQ-015 SHALL have port mem_addr, output, 9: data-memory byte address; the memory uses bits [8:1].
REQ-016 SHALL have port mem_wdata, output, 16: data-memory write word.
REQ-017 SHALL have port mem_rdata, input, 16: data-memory combinational read word.

Function
REQ-018 SHALL implement an FSM with states IDLE, ACCESS, MERGE_WR and ERR.
REQ-019 SHALL drive req_ready = 1 only in IDLE; a request is accepted at a rising edge where req_valid && req_ready.
REQ-020 SHALL, on acceptance, register write, byte, unsigned, addr and wdata, then go to ERR if the request is illegal and to ACCESS otherwise.
REQ-021 SHALL treat a word access with req_addr[0] = 1 as illegal (misaligned).
REQ-022 SHALL, in ACCESS for a word load, assert mem_read, capture mem_rdata into resp_rdata, then return to IDLE.
REQ-023 SHALL, in ACCESS for a word store, assert mem_write with mem_wdata = wdata, then return to IDLE.
REQ-024 SHALL, in ACCESS for a byte load, select mem_rdata[7:0] when addr[0] = 0 and mem_rdata[15:8] when addr[0] = 1, extend the byte per unsigned, then return to IDLE.
REQ-025 SHALL, in ACCESS for a byte store, assert mem_read, register the merged word (wdata[7:0] replacing the lane selected by addr[0]), then go to MERGE_WR.
REQ-026 SHALL, in MERGE_WR, assert mem_write with the merged word, then return to IDLE.
REQ-027 SHALL, in ERR, issue no memory strobe and return to IDLE.
REQ-028 SHALL pulse resp_valid for exactly one cycle, in the cycle after the last non-IDLE state; resp_err = 1 only for requests that went through ERR.
REQ-029 SHALL give these latencies from the acceptance edge to resp_valid: 2 cycles for word accesses, byte loads and errors; 3 cycles for byte stores.
REQ-030 SHALL allow a new request to be accepted in the same cycle that resp_valid is high.
REQ-031 SHALL drive mem_read, mem_write, mem_addr and mem_wdata combinationally from state and registers, and hold all four at 0 in IDLE and ERR.
REQ-032 SHALL never assert mem_read and mem_write in the same cycle.
REQ-033 SHALL let req_* inputs change freely outside the acceptance edge without affecting an operation in flight.

Reset
REQ-034 SHALL, on assertion of rst_n, immediately force state to IDLE and set resp_valid, resp_rdata, resp_err and all request registers to 0; mem strobes therefore drop to 0 without waiting for a clock edge.
REQ-035 SHALL discard a reset-interrupted operation entirely: no later memory write for it and no response pulse.
REQ-036 SHALL drive req_ready = 1 from the first cycle after reset deasserts.

Configuration
REQ-037 SHALL use macro LSU_BYTE_ACCESS_EN: when defined, byte loads and stores behave as in REQ-024 to REQ-026.
REQ-038 SHALL, when LSU_BYTE_ACCESS_EN is undefined, treat every request with req_byte = 1 as illegal (goes through ERR), and omit the MERGE_WR state and the merge datapath.

Verification
REQ-039 SHALL cover a word store then a word load: store 0xBEEF at addr 0x010, then load addr 0x010 -> mem_write one cycle with mem_addr 0x010; resp_rdata = 0xBEEF two cycles after load acceptance.
REQ-040 SHALL cover a misaligned word: load at addr 0x011 -> no mem_read or mem_write; resp_valid = 1 with resp_err = 1 and resp_rdata = 0.
REQ-041 SHALL cover a byte store into existing data: memory word at 0x020 = 0x1234, store byte 0xAB at 0x021 -> one mem_read, then mem_write 0xAB34; resp_valid 3 cycles after acceptance.
REQ-042 SHALL cover byte load extension: word 0x80FF at 0x030, signed byte load at 0x031 -> 0xFF80; unsigned byte load at 0x030 -> 0x00FF.
REQ-043 SHALL cover reset in MERGE_WR: rst_n low during a byte store's MERGE_WR -> mem_write = 0 asynchronously; the memory word is unchanged and no resp_valid pulse occurs.
REQ-044 SHALL cover a build without LSU_BYTE_ACCESS_EN: byte load at 0x002 -> resp_err = 1 and no memory strobe.
